// File: rtl/cpu_iob_bridge.sv
// cpu_iob_bridge: CPU data port (byte/half/word loads and stores) to a single-word IOB bus.
//
// Ports:
//   clk, reset            clock (rising edge) and asynchronous active-high reset
//   cpu_req_i..wdata_i    CPU access request, sampled only while idle
//   cpu_stall_o           CPU must freeze while an access is outstanding
//   cpu_done_o            one-cycle completion pulse
//   cpu_err_o             completion was an error (misaligned or timeout)
//   cpu_rdata_o           aligned, extended load data, valid with cpu_done_o
//   iob_valid_o..wstrb_o  IOB request (word address, replicated data, byte strobes)
//   iob_ready_i           IOB request accepted
//   iob_rvalid_i/rdata_i  IOB read response
module cpu_iob_bridge #(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned TIMEOUT_CYC = 256,
    parameter int unsigned TMO_W       = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req_i,
    input  logic              cpu_we_i,
    input  logic [1:0]        cpu_size_i,
    input  logic              cpu_unsigned_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    input  logic [DATA_W-1:0] cpu_wdata_i,
    output logic              cpu_stall_o,
    output logic              cpu_done_o,
    output logic              cpu_err_o,
    output logic [DATA_W-1:0] cpu_rdata_o,
    output logic              iob_valid_o,
    output logic [ADDR_W-3:0] iob_addr_o,
    output logic [DATA_W-1:0] iob_wdata_o,
    output logic [3:0]        iob_wstrb_o,
    input  logic              iob_ready_i,
    input  logic              iob_rvalid_i,
    input  logic [DATA_W-1:0] iob_rdata_i
);

    if (DATA_W != 32) begin : g_chk_data_w
        $error("cpu_iob_bridge: DATA_W must be 32");
    end
    if ((TMO_W < 32) && (TIMEOUT_CYC >= (32'd1 << TMO_W))) begin : g_chk_tmo_w
        $error("cpu_iob_bridge: TIMEOUT_CYC does not fit in TMO_W bits");
    end

    localparam bit               TmoEn   = (TIMEOUT_CYC != 0);
    localparam logic [TMO_W-1:0] TmoLast = TMO_W'(TmoEn ? TIMEOUT_CYC - 1 : 0);

    typedef enum logic [1:0] {StIdle, StReq, StWaitR, StDone} state_e;

    state_e              r_state;
    state_e              w_state_d;
    logic                r_we;
    logic [1:0]          r_size;
    logic                r_unsigned;
    logic [1:0]          r_lsb;
    logic [ADDR_W-3:0]   r_waddr;
    logic [DATA_W-1:0]   r_wdata;
    logic [3:0]          r_wstrb;
    logic [DATA_W-1:0]   r_rdata;
    logic                r_err;
    logic [TMO_W-1:0]    r_tmo;

    logic                w_accept;
    logic                w_misaligned;
    logic [3:0]          w_strb;
    logic [DATA_W-1:0]   w_wdata_rep;
    logic                w_tmo_hit;
    logic                w_load_cap;
    logic                w_err_d;
    logic [7:0]          w_rd_byte;
    logic [15:0]         w_rd_half;
    logic [DATA_W-1:0]   w_rd_ext;

    assign w_accept = (r_state == StIdle) && cpu_req_i;

    // Size 3 is treated as a word, so size[1] alone selects word alignment.
    assign w_misaligned = ((cpu_size_i == 2'd1) && cpu_addr_i[0]) ||
                          (cpu_size_i[1] && (cpu_addr_i[1:0] != 2'b00));

    always_comb begin
        w_strb      = 4'b1111;
        w_wdata_rep = cpu_wdata_i;
        case (cpu_size_i)
            2'd0: begin
                w_strb      = 4'b0001 << cpu_addr_i[1:0];
                w_wdata_rep = {4{cpu_wdata_i[7:0]}};
            end
            2'd1: begin
                w_strb      = 4'b0011 << {cpu_addr_i[1], 1'b0};
                w_wdata_rep = {2{cpu_wdata_i[15:0]}};
            end
            default: ;
        endcase
    end

    assign w_tmo_hit = TmoEn && (r_tmo == TmoLast);

    // Lane select and extension of the IOB read word using the captured request.
    always_comb begin
        case (r_lsb)
            2'd0:    w_rd_byte = iob_rdata_i[7:0];
            2'd1:    w_rd_byte = iob_rdata_i[15:8];
            2'd2:    w_rd_byte = iob_rdata_i[23:16];
            default: w_rd_byte = iob_rdata_i[31:24];
        endcase
        w_rd_half = r_lsb[1] ? iob_rdata_i[31:16] : iob_rdata_i[15:0];
        case (r_size)
            2'd0:    w_rd_ext = {{24{~r_unsigned & w_rd_byte[7]}}, w_rd_byte};
            2'd1:    w_rd_ext = {{16{~r_unsigned & w_rd_half[15]}}, w_rd_half};
            default: w_rd_ext = iob_rdata_i;
        endcase
    end

    always_comb begin
        w_state_d  = r_state;
        w_err_d    = r_err;
        w_load_cap = 1'b0;
        case (r_state)
            StIdle: begin
                if (cpu_req_i) begin
                    w_state_d = w_misaligned ? StDone : StReq;
                    w_err_d   = w_misaligned;
                end
            end
            StReq: begin
                // Completion takes priority over a timeout on the same cycle.
                if (iob_ready_i) begin
                    if (r_we) begin
                        w_state_d = StDone;
                    end else if (iob_rvalid_i) begin
                        w_state_d  = StDone;
                        w_load_cap = 1'b1;
                    end else begin
                        w_state_d = StWaitR;
                    end
                end else if (w_tmo_hit) begin
                    w_state_d = StDone;
                    w_err_d   = 1'b1;
                end
            end
            StWaitR: begin
                if (iob_rvalid_i) begin
                    w_state_d  = StDone;
                    w_load_cap = 1'b1;
                end else if (w_tmo_hit) begin
                    w_state_d = StDone;
                    w_err_d   = 1'b1;
                end
            end
            default: begin
                w_state_d = StIdle;
                w_err_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= StIdle;
            r_we       <= 1'b0;
            r_size     <= 2'd0;
            r_unsigned <= 1'b0;
            r_lsb      <= 2'd0;
            r_waddr    <= '0;
            r_wdata    <= '0;
            r_wstrb    <= 4'd0;
            r_rdata    <= '0;
            r_err      <= 1'b0;
            r_tmo      <= '0;
        end else begin
            r_state <= w_state_d;
            r_err   <= w_err_d;
            if (w_accept) begin
                r_we       <= cpu_we_i;
                r_size     <= cpu_size_i;
                r_unsigned <= cpu_unsigned_i;
                r_lsb      <= cpu_addr_i[1:0];
                r_waddr    <= cpu_addr_i[ADDR_W-1:2];
                r_wdata    <= w_wdata_rep;
                r_wstrb    <= cpu_we_i ? w_strb : 4'd0;
                // Cleared here so stores and error completions return zero data.
                r_rdata    <= '0;
                r_tmo      <= '0;
            end else if ((r_state == StReq) || (r_state == StWaitR)) begin
                r_tmo <= r_tmo + TMO_W'(1);
            end
            if (w_load_cap) begin
                r_rdata <= w_rd_ext;
            end
        end
    end

    assign cpu_stall_o = (r_state == StReq) || (r_state == StWaitR) || w_accept;
    assign cpu_done_o  = (r_state == StDone);
    assign cpu_err_o   = (r_state == StDone) && r_err;
    assign cpu_rdata_o = (r_state == StDone) ? r_rdata : '0;
    assign iob_valid_o = (r_state == StReq);
    assign iob_addr_o  = r_waddr;
    assign iob_wdata_o = r_wdata;
    assign iob_wstrb_o = r_wstrb;

endmodule

// File: tb/tb_cpu_iob_bridge.sv
// tb_cpu_iob_bridge: directed self-checking bench for cpu_iob_bridge (TIMEOUT_CYC=4).
// Inputs change just after a falling edge; outputs are checked on falling edges.
module tb_cpu_iob_bridge;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req_i;
    logic        cpu_we_i;
    logic [1:0]  cpu_size_i;
    logic        cpu_unsigned_i;
    logic [31:0] cpu_addr_i;
    logic [31:0] cpu_wdata_i;
    logic        cpu_stall_o;
    logic        cpu_done_o;
    logic        cpu_err_o;
    logic [31:0] cpu_rdata_o;
    logic        iob_valid_o;
    logic [29:0] iob_addr_o;
    logic [31:0] iob_wdata_o;
    logic [3:0]  iob_wstrb_o;
    logic        iob_ready_i;
    logic        iob_rvalid_i;
    logic [31:0] iob_rdata_i;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    cpu_iob_bridge #(
        .ADDR_W      (32),
        .DATA_W      (32),
        .TIMEOUT_CYC (4),
        .TMO_W       (16)
    ) u_dut (
        .clk            (clk),
        .reset          (reset),
        .cpu_req_i      (cpu_req_i),
        .cpu_we_i       (cpu_we_i),
        .cpu_size_i     (cpu_size_i),
        .cpu_unsigned_i (cpu_unsigned_i),
        .cpu_addr_i     (cpu_addr_i),
        .cpu_wdata_i    (cpu_wdata_i),
        .cpu_stall_o    (cpu_stall_o),
        .cpu_done_o     (cpu_done_o),
        .cpu_err_o      (cpu_err_o),
        .cpu_rdata_o    (cpu_rdata_o),
        .iob_valid_o    (iob_valid_o),
        .iob_addr_o     (iob_addr_o),
        .iob_wdata_o    (iob_wdata_o),
        .iob_wstrb_o    (iob_wstrb_o),
        .iob_ready_i    (iob_ready_i),
        .iob_rvalid_i   (iob_rvalid_i),
        .iob_rdata_i    (iob_rdata_i)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Present a request in IDLE for one cycle; returns on the first falling edge after acceptance.
    task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata);
        cpu_req_i      = 1'b1;
        cpu_we_i       = we;
        cpu_size_i     = size;
        cpu_unsigned_i = uns;
        cpu_addr_i     = addr;
        cpu_wdata_i    = wdata;
        #1;
        check_eq("stall_on_idle_req", {31'd0, cpu_stall_o}, 32'd1);
        @(negedge clk);
        cpu_req_i   = 1'b0;
        cpu_wdata_i = 32'd0;
    endtask

    task automatic check_done(input string tag, input logic err, input logic [31:0] rdata);
        check_eq({tag, "_done"}, {31'd0, cpu_done_o}, 32'd1);
        check_eq({tag, "_err"}, {31'd0, cpu_err_o}, {31'd0, err});
        check_eq({tag, "_stall"}, {31'd0, cpu_stall_o}, 32'd0);
        check_eq({tag, "_valid"}, {31'd0, iob_valid_o}, 32'd0);
        check_eq({tag, "_rdata"}, cpu_rdata_o, rdata);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish, expected finish before 100000");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset          = 1'b1;
        cpu_req_i      = 1'b0;
        cpu_we_i       = 1'b0;
        cpu_size_i     = 2'd0;
        cpu_unsigned_i = 1'b0;
        cpu_addr_i     = 32'd0;
        cpu_wdata_i    = 32'd0;
        iob_ready_i    = 1'b0;
        iob_rvalid_i   = 1'b0;
        iob_rdata_i    = 32'd0;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check_eq("rst_valid", {31'd0, iob_valid_o}, 32'd0);
        check_eq("rst_done", {31'd0, cpu_done_o}, 32'd0);
        check_eq("rst_err", {31'd0, cpu_err_o}, 32'd0);
        check_eq("rst_stall", {31'd0, cpu_stall_o}, 32'd0);
        check_eq("rst_rdata", cpu_rdata_o, 32'd0);
        check_eq("rst_addr", {2'd0, iob_addr_o}, 32'd0);
        check_eq("rst_wdata", iob_wdata_o, 32'd0);
        check_eq("rst_wstrb", {28'd0, iob_wstrb_o}, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Word store 0x100, ready on the third REQ cycle
        issue(1'b1, 2'd2, 1'b0, 32'h0000_0100, 32'hDEAD_BEEF);
        for (int c = 0; c < 3; c++) begin
            check_eq("wst_valid", {31'd0, iob_valid_o}, 32'd1);
            check_eq("wst_stall", {31'd0, cpu_stall_o}, 32'd1);
            check_eq("wst_addr", {2'd0, iob_addr_o}, 32'h40);
            check_eq("wst_wstrb", {28'd0, iob_wstrb_o}, 32'hF);
            check_eq("wst_wdata", iob_wdata_o, 32'hDEAD_BEEF);
            if (c == 2) iob_ready_i = 1'b1;
            @(negedge clk);
        end
        iob_ready_i = 1'b0;
        check_done("wst", 1'b0, 32'd0);
        @(negedge clk);
        check_eq("wst_idle_done", {31'd0, cpu_done_o}, 32'd0);

        // Byte store 0x103
        issue(1'b1, 2'd0, 1'b0, 32'h0000_0103, 32'h0000_00A5);
        check_eq("bst_wstrb", {28'd0, iob_wstrb_o}, 32'h8);
        check_eq("bst_wdata", iob_wdata_o, 32'hA5A5_A5A5);
        check_eq("bst_addr", {2'd0, iob_addr_o}, 32'h40);
        iob_ready_i = 1'b1;
        @(negedge clk);
        iob_ready_i = 1'b0;
        check_done("bst", 1'b0, 32'd0);
        @(negedge clk);

        // Half store 0x0A: upper lanes
        issue(1'b1, 2'd1, 1'b0, 32'h0000_000A, 32'h1234_5678);
        check_eq("hst_wstrb", {28'd0, iob_wstrb_o}, 32'hC);
        check_eq("hst_wdata", iob_wdata_o, 32'h5678_5678);
        iob_ready_i = 1'b1;
        @(negedge clk);
        iob_ready_i = 1'b0;
        check_done("hst", 1'b0, 32'd0);
        @(negedge clk);

        // Signed byte load 0x202; rvalid lands on the last timeout count, completion must win
        issue(1'b0, 2'd0, 1'b0, 32'h0000_0202, 32'd0);
        check_eq("sbl_valid", {31'd0, iob_valid_o}, 32'd1);
        check_eq("sbl_wstrb", {28'd0, iob_wstrb_o}, 32'h0);
        check_eq("sbl_addr", {2'd0, iob_addr_o}, 32'h80);
        iob_ready_i = 1'b1;
        @(negedge clk);
        iob_ready_i = 1'b0;
        for (int c = 0; c < 3; c++) begin
            check_eq("sbl_wait_valid", {31'd0, iob_valid_o}, 32'd0);
            check_eq("sbl_wait_stall", {31'd0, cpu_stall_o}, 32'd1);
            check_eq("sbl_wait_done", {31'd0, cpu_done_o}, 32'd0);
            check_eq("sbl_wait_rdata", cpu_rdata_o, 32'd0);
            if (c == 2) begin
                iob_rvalid_i = 1'b1;
                iob_rdata_i  = 32'h0080_0000;
            end
            @(negedge clk);
        end
        iob_rvalid_i = 1'b0;
        iob_rdata_i  = 32'd0;
        check_done("sbl", 1'b0, 32'hFFFF_FF80);
        @(negedge clk);
        check_eq("sbl_idle_rdata", cpu_rdata_o, 32'd0);

        // Unsigned half load 0x06, ready and rvalid together
        issue(1'b0, 2'd1, 1'b1, 32'h0000_0006, 32'd0);
        check_eq("uhl_addr", {2'd0, iob_addr_o}, 32'h1);
        iob_ready_i  = 1'b1;
        iob_rvalid_i = 1'b1;
        iob_rdata_i  = 32'hBEEF_1234;
        @(negedge clk);
        iob_ready_i  = 1'b0;
        iob_rvalid_i = 1'b0;
        check_done("uhl", 1'b0, 32'h0000_BEEF);
        @(negedge clk);

        // Signed half load 0x04, lower lane with sign bit set
        issue(1'b0, 2'd1, 1'b0, 32'h0000_0004, 32'd0);
        iob_ready_i  = 1'b1;
        iob_rvalid_i = 1'b1;
        iob_rdata_i  = 32'h7777_8001;
        @(negedge clk);
        iob_ready_i  = 1'b0;
        iob_rvalid_i = 1'b0;
        check_done("shl", 1'b0, 32'hFFFF_8001);
        @(negedge clk);

        // Misaligned word load 0x102: no IOB request, immediate error completion
        issue(1'b0, 2'd2, 1'b0, 32'h0000_0102, 32'd0);
        check_done("mwl", 1'b1, 32'd0);
        @(negedge clk);

        // Misaligned half store 0x101
        issue(1'b1, 2'd1, 1'b0, 32'h0000_0101, 32'h0000_FFFF);
        check_done("mhs", 1'b1, 32'd0);
        @(negedge clk);

        // Timeout: ready never comes, valid for exactly 4 cycles
        issue(1'b1, 2'd2, 1'b0, 32'h0000_0010, 32'h1234_5678);
        for (int c = 0; c < 4; c++) begin
            check_eq("tmo_valid", {31'd0, iob_valid_o}, 32'd1);
            check_eq("tmo_no_done", {31'd0, cpu_done_o}, 32'd0);
            @(negedge clk);
        end
        check_done("tmo", 1'b1, 32'd0);
        @(negedge clk);
        // Late response and stray ready while idle
        iob_rvalid_i = 1'b1;
        iob_ready_i  = 1'b1;
        iob_rdata_i  = 32'hFFFF_FFFF;
        @(negedge clk);
        iob_rvalid_i = 1'b0;
        iob_ready_i  = 1'b0;
        check_eq("stray_done", {31'd0, cpu_done_o}, 32'd0);
        check_eq("stray_valid", {31'd0, iob_valid_o}, 32'd0);
        check_eq("stray_stall", {31'd0, cpu_stall_o}, 32'd0);

        // Next request proceeds normally
        issue(1'b0, 2'd2, 1'b0, 32'h0000_0020, 32'd0);
        check_eq("post_valid", {31'd0, iob_valid_o}, 32'd1);
        check_eq("post_addr", {2'd0, iob_addr_o}, 32'h8);
        iob_ready_i  = 1'b1;
        iob_rvalid_i = 1'b1;
        iob_rdata_i  = 32'hCAFE_F00D;
        @(negedge clk);
        iob_ready_i  = 1'b0;
        iob_rvalid_i = 1'b0;
        check_done("post", 1'b0, 32'hCAFE_F00D);
        @(negedge clk);

        // Reset mid-transaction
        issue(1'b1, 2'd2, 1'b0, 32'h0000_0040, 32'hAAAA_5555);
        check_eq("mid_valid_pre", {31'd0, iob_valid_o}, 32'd1);
        reset = 1'b1;
        #1;
        check_eq("mid_valid_rst", {31'd0, iob_valid_o}, 32'd0);
        check_eq("mid_stall_rst", {31'd0, cpu_stall_o}, 32'd0);
        check_eq("mid_wstrb_rst", {28'd0, iob_wstrb_o}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_eq("mid_done_after", {31'd0, cpu_done_o}, 32'd0);
        check_eq("mid_valid_after", {31'd0, iob_valid_o}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
